// File: rtl/result_sink.sv
// Output-side memory writer: pops data_depth words from the output FIFO and
// writes them to memory at base+index, reporting done/busy/stall on status_reg.
module result_sink #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE_M = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start_i,
  input  logic                  empty_i,
  input  logic [127:0]          config_reg,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  RE_fifo_o,
  output logic                  WE_mem_o,
  output logic [MEM_SIZE_M-1:0] addr_Mem_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [7:0]            status_reg
);

  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

  state_t                state, state_nxt;
  logic [7:0]            cnt;
  logic [MEM_SIZE_M-1:0] addr_save;
  logic [MEM_SIZE_M-1:0] base;
  logic [7:0]            data_depth;
  logic [7:0]            offset;
  logic [1:0]            mode;
  logic                  re;
  logic                  done;
  logic                  busy;
  logic                  stop_empty;
  logic                  unused_cfg;

  assign data_depth = config_reg[7:0];
  assign offset     = config_reg[15:8];
  assign mode       = config_reg[17:16];
  assign unused_cfg = ^config_reg[127:18];

  // Mode 11 is reserved and falls back to a zero base like mode 00.
  always_comb begin
    case (mode)
      2'b01:   base = MEM_SIZE_M'(offset);
      2'b10:   base = addr_save;
      default: base = '0;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    re         = 1'b0;
    done       = 1'b0;
    busy       = 1'b0;
    stop_empty = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) state_nxt = READ;
      end
      READ: begin
        busy = 1'b1;
        if (start_i)                 state_nxt = IDLE;
        else if (cnt == data_depth)  state_nxt = DONE;
        else if (empty_i)            stop_empty = 1'b1;
        else                         re = 1'b1;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign RE_fifo_o  = re;
  assign data_o     = data_i;
  assign status_reg = {5'b0, stop_empty, busy, done};

  // The write lags the FIFO pop by one cycle because FIFO data arrives a cycle after RE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_save  <= '0;
      WE_mem_o   <= 1'b0;
      addr_Mem_o <= '0;
    end else begin
      state    <= state_nxt;
      WE_mem_o <= re;
      if (state == IDLE && start_i)
        cnt <= '0;
      else if (re)
        cnt <= cnt + 8'd1;
      if (re)
        addr_Mem_o <= base + MEM_SIZE_M'(cnt);
      if (state == DONE && mode == 2'b10)
        addr_save <= base + MEM_SIZE_M'(data_depth);
    end
  end

endmodule

// File: tb/tb_result_sink.sv
// Directed self-checking bench for result_sink: FIFO model in the tick task,
// a passive monitor logs writes/reads/done, and each scenario task checks them.
module tb_result_sink;

  logic         clk;
  logic         rstn;
  logic         start_i;
  logic         empty_i;
  logic [127:0] config_reg;
  logic [31:0]  data_i;
  logic         RE_fifo_o;
  logic         WE_mem_o;
  logic [7:0]   addr_Mem_o;
  logic [31:0]  data_o;
  logic [7:0]   status_reg;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc;

  logic [31:0] fifo[$];
  logic [7:0]  we_addr[$];
  logic [31:0] we_data[$];
  int          we_cyc[$];
  int          re_cnt, re_first, re_last, done_cnt, done_cyc;

  result_sink #(.DATA_WIDTH(32), .MEM_SIZE_M(8)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start_i    (start_i),
    .empty_i    (empty_i),
    .config_reg (config_reg),
    .data_i     (data_i),
    .RE_fifo_o  (RE_fifo_o),
    .WE_mem_o   (WE_mem_o),
    .addr_Mem_o (addr_Mem_o),
    .data_o     (data_o),
    .status_reg (status_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rstn) begin
      if (WE_mem_o) begin
        we_addr.push_back(addr_Mem_o);
        we_data.push_back(data_o);
        we_cyc.push_back(cyc);
      end
      if (status_reg[0]) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (RE_fifo_o) begin
        if (re_cnt == 0) re_first = cyc;
        re_last = cyc;
        re_cnt++;
      end
    end
  end

  // One clock: the FIFO model presents the popped word just after the edge.
  task automatic tick();
    logic re_prev;
    @(negedge clk);
    re_prev = RE_fifo_o;
    @(posedge clk);
    #1;
    if (re_prev && fifo.size() > 0) data_i = fifo.pop_front();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_logs();
    we_addr.delete(); we_data.delete(); we_cyc.delete();
    re_cnt = 0; re_first = -1; re_last = -1; done_cnt = 0; done_cyc = -1;
  endtask

  task automatic fill(input logic [31:0] first, input int n);
    fifo.delete();
    for (int i = 0; i < n; i++) fifo.push_back(first + 32'(i));
  endtask

  task automatic start_run(input logic [7:0] depth, input logic [7:0] off, input logic [1:0] md);
    config_reg = {110'b0, md, off, depth};
    start_i    = 1'b1;
    start_cyc  = cyc;
    tick();
    start_i    = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; start_i = 1'b0; empty_i = 1'b0; config_reg = '0; data_i = '0;
    ticks(3);
    n_checks++; if (WE_mem_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_we: got %0h expected 0", WE_mem_o); end
    n_checks++; if (addr_Mem_o !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_addr: got %0h expected 0", addr_Mem_o); end
    n_checks++; if (status_reg !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_status: got %0h expected 0", status_reg); end
    n_checks++; if (RE_fifo_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_re: got %0h expected 0", RE_fifo_o); end
    rstn = 1'b1;
    ticks(2);
  endtask

  task automatic test_mode00();
    $display("[TB] mode 00, depth 4");
    fill(32'hA0, 4); clear_logs();
    start_run(8'd4, 8'h00, 2'b00);
    #1;
    n_checks++; if (status_reg !== 8'h02) begin n_fail++; $display("[TB] FAIL m00_busy: got %0h expected 02", status_reg); end
    ticks(8);
    n_checks++; if (re_cnt !== 4) begin n_fail++; $display("[TB] FAIL m00_re_count: got %0d expected 4", re_cnt); end
    n_checks++; if (re_first !== start_cyc + 1 || re_last !== start_cyc + 4) begin n_fail++; $display("[TB] FAIL m00_re_window: got %0d..%0d expected %0d..%0d", re_first, re_last, start_cyc + 1, start_cyc + 4); end
    n_checks++; if (we_addr.size() !== 4) begin n_fail++; $display("[TB] FAIL m00_we_count: got %0d expected 4", we_addr.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++; if (we_addr[i] !== 8'(i) || we_data[i] !== 32'hA0 + 32'(i)) begin n_fail++; $display("[TB] FAIL m00_write%0d: got %0h/%0h expected %0h/%0h", i, we_addr[i], we_data[i], i, 32'hA0 + 32'(i)); end
      end
      n_checks++; if (we_cyc[0] !== start_cyc + 2) begin n_fail++; $display("[TB] FAIL m00_first_we_cycle: got %0d expected %0d", we_cyc[0], start_cyc + 2); end
      n_checks++; if (done_cyc !== we_cyc[3] + 1) begin n_fail++; $display("[TB] FAIL m00_done_cycle: got %0d expected %0d", done_cyc, we_cyc[3] + 1); end
    end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("[TB] FAIL m00_done_count: got %0d expected 1", done_cnt); end
    n_checks++; if (status_reg !== 8'h00) begin n_fail++; $display("[TB] FAIL m00_idle_status: got %0h expected 0", status_reg); end
  endtask

  task automatic test_mode01();
    $display("[TB] mode 01, offset 0x10, depth 3");
    fill(32'hB0, 3); clear_logs();
    start_run(8'd3, 8'h10, 2'b01);
    ticks(7);
    n_checks++; if (we_addr.size() !== 3) begin n_fail++; $display("[TB] FAIL m01_we_count: got %0d expected 3", we_addr.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++; if (we_addr[i] !== 8'h10 + 8'(i) || we_data[i] !== 32'hB0 + 32'(i)) begin n_fail++; $display("[TB] FAIL m01_write%0d: got %0h/%0h expected %0h/%0h", i, we_addr[i], we_data[i], 8'h10 + 8'(i), 32'hB0 + 32'(i)); end
      end
    end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("[TB] FAIL m01_done_count: got %0d expected 1", done_cnt); end
    n_checks++; if (status_reg !== 8'h00) begin n_fail++; $display("[TB] FAIL m01_busy_after: got %0h expected 0", status_reg); end
  endtask

  task automatic test_mode10();
    $display("[TB] mode 10, chained runs of 4, 2, 1");
    fill(32'hD0, 4); clear_logs();
    start_run(8'd4, 8'h00, 2'b10);
    ticks(8);
    fill(32'hD4, 2);
    start_run(8'd2, 8'h00, 2'b10);
    ticks(6);
    fill(32'hD6, 1);
    start_run(8'd1, 8'h00, 2'b10);
    ticks(5);
    n_checks++; if (we_addr.size() !== 7) begin n_fail++; $display("[TB] FAIL m10_we_count: got %0d expected 7", we_addr.size()); end
    else begin
      for (int i = 0; i < 7; i++) begin
        n_checks++; if (we_addr[i] !== 8'(i) || we_data[i] !== 32'hD0 + 32'(i)) begin n_fail++; $display("[TB] FAIL m10_write%0d: got %0h/%0h expected %0h/%0h", i, we_addr[i], we_data[i], i, 32'hD0 + 32'(i)); end
      end
    end
    n_checks++; if (done_cnt !== 3) begin n_fail++; $display("[TB] FAIL m10_done_count: got %0d expected 3", done_cnt); end
  endtask

  task automatic test_stall();
    $display("[TB] empty stall, depth 6");
    fill(32'hC0, 6); clear_logs();
    start_run(8'd6, 8'h00, 2'b00);
    ticks(2);
    empty_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (RE_fifo_o !== 1'b0 || status_reg !== 8'h06) begin n_fail++; $display("[TB] FAIL stall_cycle%0d: got re=%0h status=%0h expected re=0 status=06", i, RE_fifo_o, status_reg); end
      tick();
    end
    empty_i = 1'b0;
    ticks(10);
    n_checks++; if (re_cnt !== 6) begin n_fail++; $display("[TB] FAIL stall_re_count: got %0d expected 6", re_cnt); end
    n_checks++; if (we_addr.size() !== 6) begin n_fail++; $display("[TB] FAIL stall_we_count: got %0d expected 6", we_addr.size()); end
    else begin
      for (int i = 0; i < 6; i++) begin
        n_checks++; if (we_addr[i] !== 8'(i) || we_data[i] !== 32'hC0 + 32'(i)) begin n_fail++; $display("[TB] FAIL stall_write%0d: got %0h/%0h expected %0h/%0h", i, we_addr[i], we_data[i], i, 32'hC0 + 32'(i)); end
      end
    end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("[TB] FAIL stall_done_count: got %0d expected 1", done_cnt); end
  endtask

  // Uses mode 10 so that an unchanged addr_save (7) shows up in the follow-up run.
  task automatic test_abort();
    $display("[TB] abort after two reads");
    fill(32'hE0, 8); clear_logs();
    start_run(8'd8, 8'h00, 2'b10);
    ticks(2);
    start_i = 1'b1;
    #1;
    n_checks++; if (RE_fifo_o !== 1'b0 || status_reg !== 8'h02) begin n_fail++; $display("[TB] FAIL abort_request: got re=%0h status=%0h expected re=0 status=02", RE_fifo_o, status_reg); end
    tick();
    start_i = 1'b0;
    #1;
    n_checks++; if (RE_fifo_o !== 1'b0 || status_reg !== 8'h00) begin n_fail++; $display("[TB] FAIL abort_idle: got re=%0h status=%0h expected re=0 status=00", RE_fifo_o, status_reg); end
    ticks(5);
    n_checks++; if (we_addr.size() !== 2) begin n_fail++; $display("[TB] FAIL abort_we_count: got %0d expected 2", we_addr.size()); end
    else begin
      n_checks++; if (we_addr[0] !== 8'h07 || we_addr[1] !== 8'h08 || we_data[1] !== 32'hE1) begin n_fail++; $display("[TB] FAIL abort_writes: got %0h,%0h/%0h expected 07,08/e1", we_addr[0], we_addr[1], we_data[1]); end
    end
    n_checks++; if (done_cnt !== 0) begin n_fail++; $display("[TB] FAIL abort_no_done: got %0d expected 0", done_cnt); end
    fill(32'hF0, 1); clear_logs();
    start_run(8'd1, 8'h00, 2'b10);
    ticks(5);
    n_checks++; if (we_addr.size() !== 1 || we_addr[0] !== 8'h07) begin n_fail++; $display("[TB] FAIL abort_addr_save: got n=%0d addr=%0h expected n=1 addr=07", we_addr.size(), we_addr.size() > 0 ? we_addr[0] : 8'hxx); end
  endtask

  task automatic test_zero_depth_and_reset();
    $display("[TB] depth 0, then reset mid-transfer");
    fifo.delete(); clear_logs();
    start_run(8'd0, 8'h00, 2'b00);
    ticks(4);
    n_checks++; if (re_cnt !== 0 || we_addr.size() !== 0) begin n_fail++; $display("[TB] FAIL zero_no_traffic: got re=%0d we=%0d expected 0/0", re_cnt, we_addr.size()); end
    n_checks++; if (done_cnt !== 1 || done_cyc !== start_cyc + 2) begin n_fail++; $display("[TB] FAIL zero_done: got n=%0d cycle=%0d expected n=1 cycle=%0d", done_cnt, done_cyc, start_cyc + 2); end
    fill(32'h90, 8); clear_logs();
    start_run(8'd8, 8'h00, 2'b00);
    ticks(2);
    rstn = 1'b0;
    #1;
    n_checks++; if (WE_mem_o !== 1'b0 || addr_Mem_o !== 8'h00 || status_reg !== 8'h00 || RE_fifo_o !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_outputs: got we=%0h addr=%0h status=%0h re=%0h expected all 0", WE_mem_o, addr_Mem_o, status_reg, RE_fifo_o); end
    ticks(2);
    rstn = 1'b1;
    ticks(4);
    n_checks++; if (RE_fifo_o !== 1'b0 || status_reg !== 8'h00) begin n_fail++; $display("[TB] FAIL midreset_idle: got re=%0h status=%0h expected 0/0", RE_fifo_o, status_reg); end
    n_checks++; if (we_addr.size() !== 1 || done_cnt !== 0) begin n_fail++; $display("[TB] FAIL midreset_traffic: got we=%0d done=%0d expected 1/0", we_addr.size(), done_cnt); end
  endtask

  initial begin
    test_reset();
    test_mode00();
    test_mode01();
    test_mode10();
    test_stall();
    test_abort();
    test_zero_depth_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
